// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// IF looks up the fetch PC combinationally and receives a predicted next PC.
// EX reports each resolved branch/jump. The block then updates the table,
// flags mispredicts, supplies the redirect PC and keeps two statistics counters.
//
// Handshake: ex_update_i is a single-cycle valid qualifier with no ready. The
// table always accepts an update in the cycle it is presented, unless rst_ni
// is low. In that case the update is discarded.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_next_pc_o,
  input  logic              ex_update_i,
  input  logic              ex_is_jump_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic              ex_taken_i,
  input  logic [XLEN-1:0]   ex_target_i,
  input  logic              ex_pred_taken_i,
  input  logic [XLEN-1:0]   ex_pred_next_pc_i,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [PERF_W-1:0] branch_cnt_o,
  output logic [PERF_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_N = CNT_WEAK_T - CNT_W'(1);

  // Table storage. Every read is asynchronous, so flops or LUT-RAM both fit.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [PERF_W-1:0] branch_cnt_q;
  logic [PERF_W-1:0] mispred_cnt_q;

  // Field decode for the fetch-side lookup.
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  assign if_idx = if_pc_i[IDX_W+1:2];
  assign if_tag = if_pc_i[XLEN-1:IDX_W+2];

  // Lookup returns stored state only. An update to the same entry in the
  // same cycle becomes visible one cycle later, because there is no bypass.
  assign pred_hit_o     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken_o   = pred_hit_o && cnt_q[if_idx][CNT_W-1];
  assign pred_next_pc_o = pred_taken_o ? target_q[if_idx] : (if_pc_i + XLEN'(4));

  // Field decode and hit detection for the EX-side update.
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;
  assign upd_idx = ex_pc_i[IDX_W+1:2];
  assign upd_tag = ex_pc_i[XLEN-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_cnt = cnt_q[upd_idx];
  assign cnt_inc = (upd_cnt == CNT_MAX) ? upd_cnt : (upd_cnt + CNT_W'(1));
  assign cnt_dec = (upd_cnt == '0) ? upd_cnt : (upd_cnt - CNT_W'(1));

  // A prediction is wrong if it got the direction wrong, or if it got the
  // target of a taken instruction wrong.
  assign mispredict_o  = ex_update_i &&
                         ((ex_taken_i != ex_pred_taken_i) ||
                          (ex_taken_i && (ex_target_i != ex_pred_next_pc_i)));
  assign redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + XLEN'(4));

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // Table update and reset. Tags and targets are left unreset because the
  // valid bit hides them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WEAK_N;
      end
    end else if (ex_update_i) begin
      if (upd_hit) begin
        if (ex_is_jump_i) begin
          cnt_q[upd_idx]    <= CNT_MAX;
          target_q[upd_idx] <= ex_target_i;
        end else if (ex_taken_i) begin
          cnt_q[upd_idx]    <= cnt_inc;
          target_q[upd_idx] <= ex_target_i;
        end else begin
          cnt_q[upd_idx]    <= cnt_dec;
        end
      end else if (ex_taken_i) begin
        // Allocate the entry, or replace an aliasing entry at the same index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= ex_target_i;
        cnt_q[upd_idx]    <= ex_is_jump_i ? CNT_MAX : CNT_WEAK_T;
      end
    end
  end

  // Statistics counters. Both wrap naturally at their width.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ex_update_i) branch_cnt_q  <= branch_cnt_q + PERF_W'(1);
      if (mispredict_o) mispred_cnt_q <= mispred_cnt_q + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. It runs directed scenarios and
// then randomized traffic, both checked against a behavioural table model.
module tb_branch_predictor;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int CNT_W   = 2;
  localparam int PERF_W  = 32;
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int WEAK_T  = 1 << (CNT_W - 1);

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [XLEN-1:0]   if_pc_i = '0;
  logic              pred_hit_o;
  logic              pred_taken_o;
  logic [XLEN-1:0]   pred_next_pc_o;
  logic              ex_update_i = 1'b0;
  logic              ex_is_jump_i = 1'b0;
  logic [XLEN-1:0]   ex_pc_i = '0;
  logic              ex_taken_i = 1'b0;
  logic [XLEN-1:0]   ex_target_i = '0;
  logic              ex_pred_taken_i = 1'b0;
  logic [XLEN-1:0]   ex_pred_next_pc_i = '0;
  logic              mispredict_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic [PERF_W-1:0] branch_cnt_o;
  logic [PERF_W-1:0] mispred_cnt_o;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .if_pc_i(if_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_next_pc_o(pred_next_pc_o),
    .ex_update_i(ex_update_i), .ex_is_jump_i(ex_is_jump_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_pred_next_pc_i(ex_pred_next_pc_i), .mispredict_o(mispredict_o),
    .redirect_pc_o(redirect_pc_o), .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each index slot remembers which instruction (by PC upper bits) owns it,
  // where that instruction last went, and a confidence level held as an int.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_conf  [ENTRIES];
  logic [31:0] exp_branch;
  logic [31:0] exp_mispred;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_owner[m_idx(pc)] == m_tagof(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_conf[m_idx(pc)] >= WEAK_T);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispred(input bit taken, input logic [31:0] target,
                                   input bit pt, input logic [31:0] pn);
    return (taken != pt) || (taken && (target != pn));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_conf[i]  = WEAK_T - 1;
    end
    exp_branch  = 0;
    exp_mispred = 0;
  endtask

  task automatic model_update(input logic [31:0] pc, input bit taken, input logic [31:0] target,
                              input bit jump, input bit pt, input logic [31:0] pn);
    int i;
    i = m_idx(pc);
    exp_branch = exp_branch + 1;
    if (m_mispred(taken, target, pt, pn)) exp_mispred = exp_mispred + 1;
    if (m_hit(pc)) begin
      if (jump) begin
        m_conf[i] = CMAX;
        m_tgt[i]  = target;
      end else if (taken) begin
        m_conf[i] = (m_conf[i] + 1 > CMAX) ? CMAX : m_conf[i] + 1;
        m_tgt[i]  = target;
      end else begin
        m_conf[i] = (m_conf[i] - 1 < 0) ? 0 : m_conf[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1;
      m_owner[i] = m_tagof(pc);
      m_tgt[i]   = target;
      m_conf[i]  = jump ? CMAX : WEAK_T;
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] cur_pc, cur_tgt, cur_pn;
  bit          cur_taken, cur_jump, cur_pt;

  task automatic start_update(input logic [31:0] pc, input bit taken, input logic [31:0] target,
                              input bit jump, input bit pt, input logic [31:0] pn);
    @(negedge clk_i);
    cur_pc = pc; cur_taken = taken; cur_tgt = target; cur_jump = jump; cur_pt = pt; cur_pn = pn;
    ex_pc_i = pc; ex_taken_i = taken; ex_target_i = target; ex_is_jump_i = jump;
    ex_pred_taken_i = pt; ex_pred_next_pc_i = pn;
    ex_update_i = 1'b1;
  endtask

  task automatic end_update();
    @(posedge clk_i);
    if (rst_ni) model_update(cur_pc, cur_taken, cur_tgt, cur_jump, cur_pt, cur_pn);
    else model_reset();
    #1;
    ex_update_i = 1'b0;
  endtask

  task automatic set_lookup(input logic [31:0] pc);
    @(negedge clk_i);
    if_pc_i = pc;
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    model_reset();
    #1;
    rst_ni = 1'b1;
    set_lookup(32'h100);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h104}) begin
      errors++;
      $display("FAIL reset_lookup: got hit=%0b taken=%0b next=%h, want 0 0 00000104",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    checks++;
    if ({branch_cnt_o, mispred_cnt_o} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got branch=%0d mispred=%0d, want 0 0", branch_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_alloc();
    start_update(32'h100, 1, 32'h40, 0, 0, 32'h104);
    #1;
    checks++;
    if ({mispredict_o, redirect_pc_o} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL alloc_mispredict: got mp=%0b redirect=%h, want 1 00000040", mispredict_o, redirect_pc_o);
    end
    end_update();
    set_lookup(32'h100);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h40}) begin
      errors++;
      $display("FAIL alloc_lookup: got hit=%0b taken=%0b next=%h, want 1 1 00000040",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    checks++;
    if ({branch_cnt_o, mispred_cnt_o} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL alloc_counters: got branch=%0d mispred=%0d, want 1 1", branch_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_saturate();
    bit pt;
    logic [31:0] pn;
    for (int k = 0; k < 3; k++) begin
      pt = m_taken(32'h100);
      pn = m_next(32'h100);
      start_update(32'h100, 0, {$urandom_range(0, 255), 2'b00}, 0, pt, pn);
      #1;
      checks++;
      if ({mispredict_o, redirect_pc_o} !== {(k == 0), 32'h104}) begin
        errors++;
        $display("FAIL sat_step%0d: got mp=%0b redirect=%h, want %0b 00000104",
                 k, mispredict_o, redirect_pc_o, (k == 0));
      end
      end_update();
    end
    set_lookup(32'h100);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 32'h104}) begin
      errors++;
      $display("FAIL sat_lookup: got hit=%0b taken=%0b next=%h, want 1 0 00000104",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    checks++;
    if ({branch_cnt_o, mispred_cnt_o} !== {32'd4, 32'd2}) begin
      errors++;
      $display("FAIL sat_counters: got branch=%0d mispred=%0d, want 4 2", branch_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_alias();
    set_lookup(32'h200);
    checks++;
    if (pred_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL alias_premiss: got hit=%0b, want 0", pred_hit_o);
    end
    start_update(32'h200, 1, 32'h300, 0, 0, 32'h204);
    end_update();
    set_lookup(32'h200);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL alias_new: got hit=%0b taken=%0b next=%h, want 1 1 00000300",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    set_lookup(32'h100);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, 32'h104}) begin
      errors++;
      $display("FAIL alias_evicted: got hit=%0b taken=%0b next=%h, want 0 0 00000104",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
  endtask

  task automatic test_jump();
    start_update(32'h10, 1, 32'h80, 1, 0, 32'h14);
    end_update();
    set_lookup(32'h10);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h80}) begin
      errors++;
      $display("FAIL jump_lookup: got hit=%0b taken=%0b next=%h, want 1 1 00000080",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    start_update(32'h10, 1, 32'h80, 1, 1, 32'h80);
    #1;
    checks++;
    if ({mispredict_o, redirect_pc_o} !== {1'b0, 32'h80}) begin
      errors++;
      $display("FAIL jump_correct: got mp=%0b redirect=%h, want 0 00000080", mispredict_o, redirect_pc_o);
    end
    end_update();
    #1;
    checks++;
    if ({branch_cnt_o, mispred_cnt_o} !== {32'd7, 32'd4}) begin
      errors++;
      $display("FAIL jump_counters: got branch=%0d mispred=%0d, want 7 4", branch_cnt_o, mispred_cnt_o);
    end
  endtask

  task automatic test_same_cycle();
    start_update(32'h200, 0, 32'h0, 0, 1, 32'h300);
    if_pc_i = 32'h200;
    #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b1, 32'h300}) begin
      errors++;
      $display("FAIL same_cycle_old: got hit=%0b taken=%0b next=%h, want 1 1 00000300",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
    checks++;
    if ({mispredict_o, redirect_pc_o} !== {1'b1, 32'h204}) begin
      errors++;
      $display("FAIL same_cycle_mp: got mp=%0b redirect=%h, want 1 00000204", mispredict_o, redirect_pc_o);
    end
    end_update();
    set_lookup(32'h200);
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b1, 1'b0, 32'h204}) begin
      errors++;
      $display("FAIL same_cycle_new: got hit=%0b taken=%0b next=%h, want 1 0 00000204",
               pred_hit_o, pred_taken_o, pred_next_pc_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc, tgt, pn, lk;
    bit taken, jump, pt;
    for (int n = 0; n < 400; n++) begin
      lk = rand_pc();
      if ($urandom_range(0, 3) == 0) begin
        set_lookup(lk);
        checks++;
        if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {m_hit(lk), m_taken(lk), m_next(lk)}) begin
          errors++;
          $display("FAIL rand_idle_lookup pc=%h: got %0b %0b %h, want %0b %0b %h", lk,
                   pred_hit_o, pred_taken_o, pred_next_pc_o, m_hit(lk), m_taken(lk), m_next(lk));
        end
        continue;
      end
      pc    = rand_pc();
      jump  = ($urandom_range(0, 3) == 0);
      taken = jump ? 1'b1 : 1'($urandom_range(0, 1));
      tgt   = {22'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) != 0) begin
        pt = m_taken(pc);
        pn = m_next(pc);
      end else begin
        pt = 1'($urandom_range(0, 1));
        pn = {$urandom_range(0, 1023), 2'b00};
      end
      start_update(pc, taken, tgt, jump, pt, pn);
      if_pc_i = lk;
      #1;
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {m_hit(lk), m_taken(lk), m_next(lk)}) begin
        errors++;
        $display("FAIL rand_lookup pc=%h: got %0b %0b %h, want %0b %0b %h", lk,
                 pred_hit_o, pred_taken_o, pred_next_pc_o, m_hit(lk), m_taken(lk), m_next(lk));
      end
      checks++;
      if ({mispredict_o, redirect_pc_o} !== {m_mispred(taken, tgt, pt, pn), (taken ? tgt : pc + 32'd4)}) begin
        errors++;
        $display("FAIL rand_mispredict pc=%h: got mp=%0b redirect=%h, want %0b %h", pc,
                 mispredict_o, redirect_pc_o, m_mispred(taken, tgt, pt, pn), (taken ? tgt : pc + 32'd4));
      end
      end_update();
      checks++;
      if ({branch_cnt_o, mispred_cnt_o} !== {exp_branch, exp_mispred}) begin
        errors++;
        $display("FAIL rand_counters: got branch=%0d mispred=%0d, want %0d %0d",
                 branch_cnt_o, mispred_cnt_o, exp_branch, exp_mispred);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] lk;
    @(negedge clk_i);
    rst_ni = 1'b0;
    ex_pc_i = 32'h200; ex_taken_i = 1'b1; ex_target_i = 32'h500; ex_is_jump_i = 1'b0;
    ex_pred_taken_i = 1'b0; ex_pred_next_pc_i = 32'h204;
    ex_update_i = 1'b1;
    #1;
    checks++;
    if ({mispredict_o, redirect_pc_o} !== {1'b1, 32'h500}) begin
      errors++;
      $display("FAIL reset_mid_comb: got mp=%0b redirect=%h, want 1 00000500", mispredict_o, redirect_pc_o);
    end
    @(posedge clk_i);
    model_reset();
    #1;
    rst_ni = 1'b1;
    ex_update_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      lk = (k == 0) ? 32'h200 : rand_pc();
      set_lookup(lk);
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_next_pc_o} !== {1'b0, 1'b0, lk + 32'd4}) begin
        errors++;
        $display("FAIL reset_mid_lookup pc=%h: got %0b %0b %h, want 0 0 %h", lk,
                 pred_hit_o, pred_taken_o, pred_next_pc_o, lk + 32'd4);
      end
    end
    checks++;
    if ({branch_cnt_o, mispred_cnt_o} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_counters: got branch=%0d mispred=%0d, want 0 0", branch_cnt_o, mispred_cnt_o);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_alloc();
    test_saturate();
    test_alias();
    test_jump();
    test_same_cycle();
    test_random();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
